// File: rtl/jamma_pkg.sv
// Shared types and constants for the JAMMA joystick split adapter.
// Joystick vectors are active-low; bit order matches the host's JJOY mapping.
package jamma_pkg;

  localparam int JOY_W = 8;
  localparam logic [JOY_W-1:0] JOY_IDLE = 8'hFF;

  localparam int JOY_BIT_COIN  = 0;
  localparam int JOY_BIT_UP    = 1;
  localparam int JOY_BIT_DOWN  = 2;
  localparam int JOY_BIT_LEFT  = 3;
  localparam int JOY_BIT_RIGHT = 4;
  localparam int JOY_BIT_FIRE1 = 5;
  localparam int JOY_BIT_FIRE2 = 6;
  localparam int JOY_BIT_START = 7;

  typedef logic [JOY_W-1:0] joy_t;

endpackage

// File: rtl/joy_debounce.sv
// One player's switch conditioner: 2-FF synchronizer plus per-bit debounce.
// Debouncers exist only when JAMMA_JOY_DEBOUNCE_EN is defined; otherwise the bank is the synced vector.
module joy_debounce
  import jamma_pkg::*;
#(
  parameter int DEBOUNCE_BITS = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  joy_t i_raw,
  output joy_t o_bank
);

  joy_t r_sync1;
  joy_t r_sync2;

  // Synchronizers release to the idle (not-pressed) level.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync1 <= JOY_IDLE;
      r_sync2 <= JOY_IDLE;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef JAMMA_JOY_DEBOUNCE_EN
  localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX = '1;

  logic [DEBOUNCE_BITS-1:0] r_cnt [JOY_W];
  joy_t                     r_bank;

  // A bit is accepted only after differing for 2^DEBOUNCE_BITS consecutive cycles.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_bank <= JOY_IDLE;
      for (int b = 0; b < JOY_W; b++) r_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < JOY_W; b++) begin
        if (r_sync2[b] == r_bank[b]) begin
          r_cnt[b] <= '0;
        end else if (r_cnt[b] == CNT_MAX) begin
          r_bank[b] <= r_sync2[b];
          r_cnt[b]  <= '0;
        end else begin
          r_cnt[b] <= r_cnt[b] + 1'b1;
        end
      end
    end
  end

  assign o_bank = r_bank;
`else
  // Counter width has no meaning without debouncers; keep the parameter referenced.
  logic [DEBOUNCE_BITS-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;

  assign o_bank = r_sync2;
`endif

endmodule

// File: rtl/jamma_joy_mux.sv
// JAMMA two-player joystick responder: per-player conditioning, JSELECT watchdog, output mux.
// Optional debouncing is controlled by the JAMMA_JOY_DEBOUNCE_EN macro inside joy_debounce.
module jamma_joy_mux
  import jamma_pkg::*;
#(
  parameter int DEBOUNCE_BITS = 4,
  parameter int TIMEOUT_BITS  = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       JSELECT,
  input  logic [7:0] P1_RAW,
  input  logic [7:0] P2_RAW,
  output logic [7:0] JJOY,
  output logic       SEL_ALIVE
);

  localparam logic [TIMEOUT_BITS-1:0] WD_MAX = '1;

  joy_t w_bank1;
  joy_t w_bank2;

  joy_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_p1 (
    .CLK    (CLK),
    .RESET  (RESET),
    .i_raw  (P1_RAW),
    .o_bank (w_bank1)
  );

  joy_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_p2 (
    .CLK    (CLK),
    .RESET  (RESET),
    .i_raw  (P2_RAW),
    .o_bank (w_bank2)
  );

  logic                    r_js1;
  logic                    r_js2;
  logic                    r_js_prev;
  logic [TIMEOUT_BITS-1:0] r_wd_cnt;
  logic                    r_alive;
  logic                    w_js_edge;

  assign w_js_edge = r_js2 ^ r_js_prev;

  // An edge always wins over saturation; alive drops on the cycle the counter saturates.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_js1     <= 1'b1;
      r_js2     <= 1'b1;
      r_js_prev <= 1'b1;
      r_wd_cnt  <= '0;
      r_alive   <= 1'b0;
    end else begin
      r_js1     <= JSELECT;
      r_js2     <= r_js1;
      r_js_prev <= r_js2;
      if (w_js_edge) begin
        r_wd_cnt <= '0;
        r_alive  <= 1'b1;
      end else if (r_wd_cnt != WD_MAX) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
        if (r_wd_cnt == WD_MAX - 1'b1) r_alive <= 1'b0;
      end
    end
  end

  assign SEL_ALIVE = r_alive;

  // Raw JSELECT steers the mux so the host sees the bank within the same cycle.
  always_comb begin
    JJOY = w_bank1 & w_bank2;
    if (r_alive) JJOY = JSELECT ? w_bank2 : w_bank1;
  end

endmodule

// File: tb/tb_jamma_joy_mux.sv
// Self-checking bench for jamma_joy_mux: directed scenarios plus randomized stimulus,
// all checked every cycle against a delay-line / run-length / timestamp reference model.
module tb_jamma_joy_mux;

`ifdef JAMMA_JOY_DEBOUNCE_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 2;
`endif
  localparam int RUN_LEN  = 16;
  localparam int WD_LIMIT = 255;

  logic       CLK;
  logic       RESET;
  logic       JSELECT;
  logic [7:0] P1_RAW;
  logic [7:0] P2_RAW;
  logic [7:0] JJOY;
  logic       SEL_ALIVE;

  int n_cmp  = 0;
  int n_fail = 0;

  jamma_joy_mux dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .JSELECT   (JSELECT),
    .P1_RAW    (P1_RAW),
    .P2_RAW    (P2_RAW),
    .JJOY      (JJOY),
    .SEL_ALIVE (SEL_ALIVE)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // reference model: inputs reach the banks through a two-stage delay line;
  // a bank bit flips once the delayed value has disagreed for RUN_LEN edges in a row;
  // the select is alive while the last detected select edge is fewer than WD_LIMIT edges old.
  logic [7:0] m_d1 [2];
  logic [7:0] m_d2 [2];
  logic [7:0] m_bank [2];
  int         m_run [2][8];
  logic       m_j1, m_j2, m_j3;
  int         m_cyc = 0;
  int         m_last_edge = 0;
  bit         m_have_edge = 0;
  bit         m_ready = 0;

  always @(posedge CLK) begin
    logic [7:0] raw_now [2];
    logic [7:0] old_d2;
    raw_now[0] = P1_RAW;
    raw_now[1] = P2_RAW;
    m_cyc++;
    if (RESET) begin
      m_ready     = 1;
      m_have_edge = 0;
      m_j1 = 1'b1; m_j2 = 1'b1; m_j3 = 1'b1;
      for (int p = 0; p < 2; p++) begin
        m_d1[p] = 8'hFF; m_d2[p] = 8'hFF; m_bank[p] = 8'hFF;
        for (int b = 0; b < 8; b++) m_run[p][b] = 0;
      end
    end else begin
      if (m_j2 != m_j3) begin
        m_have_edge = 1;
        m_last_edge = m_cyc;
      end
      m_j3 = m_j2; m_j2 = m_j1; m_j1 = JSELECT;
      for (int p = 0; p < 2; p++) begin
        old_d2  = m_d2[p];
        m_d2[p] = m_d1[p];
        m_d1[p] = raw_now[p];
`ifdef JAMMA_JOY_DEBOUNCE_EN
        for (int b = 0; b < 8; b++) begin
          if (old_d2[b] != m_bank[p][b]) m_run[p][b]++;
          else m_run[p][b] = 0;
          if (m_run[p][b] == RUN_LEN) begin
            m_bank[p][b] = old_d2[b];
            m_run[p][b]  = 0;
          end
        end
`else
        m_bank[p] = m_d2[p];
`endif
      end
    end
  end

  function automatic logic exp_alive();
    return m_have_edge && ((m_cyc - m_last_edge) < WD_LIMIT);
  endfunction

  function automatic logic [7:0] exp_jjoy(input logic js);
    if (exp_alive()) return js ? m_bank[1] : m_bank[0];
    return m_bank[0] & m_bank[1];
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, got, want);
    end
  endtask

  // driver tasks: one clock, optional JSELECT toggle just after the edge, model compare at negedge
  task automatic tick(input bit tog);
    @(posedge CLK);
    #1;
    if (tog) JSELECT = ~JSELECT;
    @(negedge CLK);
    if (m_ready) begin
      check("model_jjoy", JJOY, exp_jjoy(JSELECT));
      check("model_alive", {7'b0, SEL_ALIVE}, {7'b0, exp_alive()});
    end
  endtask

  // Briefly steer the combinational mux to read one bank, then restore the select.
  task automatic probe(input string name, input logic sel, input logic [7:0] want);
    logic       save;
    logic [7:0] got;
    #2;
    save = JSELECT;
    JSELECT = sel;
    #1;
    got = JJOY;
    JSELECT = save;
    check(name, got, want);
  endtask

  initial begin
    int k;
    bit tog;
    int len;
    RESET = 1'b1; JSELECT = 1'b1; P1_RAW = 8'hFF; P2_RAW = 8'hFF;

    // reset and idle
    for (int i = 0; i < 4; i++) begin
      tick(0);
      check("rst_jjoy", JJOY, 8'hFF);
      check("rst_alive", {7'b0, SEL_ALIVE}, 8'h00);
    end
    RESET = 1'b0;
    for (int i = 0; i < 300; i++) tick(0);
    check("idle_alive", {7'b0, SEL_ALIVE}, 8'h00);
    check("idle_jjoy", JJOY, 8'hFF);

    // debounce accept
    for (int i = 0; i < 12; i++) tick(1);
    check("toggle_alive", {7'b0, SEL_ALIVE}, 8'h01);
    P1_RAW = 8'hFB;
    for (k = 1; k <= LAT; k++) begin
      tick(1);
      if (k == LAT - 1) probe("press_before", 1'b0, 8'hFF);
      if (k == LAT) begin
        probe("press_accept", 1'b0, 8'hFB);
        probe("press_p2_idle", 1'b1, 8'hFF);
      end
    end
    for (int i = 0; i < 4; i++) tick(1);

    // glitch reject
    P2_RAW = 8'hDF;
    for (int i = 0; i < 10; i++) begin
      tick(1);
`ifdef JAMMA_JOY_DEBOUNCE_EN
      probe("glitch_bank2", 1'b1, 8'hFF);
`endif
    end
    P2_RAW = 8'hFF;
    for (int i = 0; i < 25; i++) begin
      tick(1);
`ifdef JAMMA_JOY_DEBOUNCE_EN
      probe("glitch_bank2", 1'b1, 8'hFF);
`endif
    end

    // randomized segments: mixed hold lengths, toggling or stalled select, rare resets
    for (int seg = 0; seg < 8; seg++) begin
      tog = ($urandom_range(0, 2) != 0);
      len = $urandom_range(100, 400);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          if ($urandom_range(0, 1) == 0) P1_RAW[$urandom_range(0, 7)] = 1'($urandom_range(0, 1));
          else P2_RAW[$urandom_range(0, 7)] = 1'($urandom_range(0, 1));
        end
        RESET = ($urandom_range(0, 499) == 0);
        tick(tog);
      end
      RESET = 1'b0;
    end

    // watchdog fallback
    P1_RAW = 8'hFF; P2_RAW = 8'hFF;
    for (int i = 0; i < 20; i++) tick(1);
    P1_RAW = 8'hFE; P2_RAW = 8'hBF;
    if (JSELECT == 1'b1) tick(1);
    tick(1);
    k = 0;
    while (SEL_ALIVE == 1'b1 && k < 400) begin
      tick(0);
      k++;
    end
    check("wd_fall_cycles", 8'(k), 8'(258));
    for (int i = 0; i < 5; i++) tick(0);
    check("wd_merged_jjoy", JJOY, 8'hBE);
    check("wd_alive_low", {7'b0, SEL_ALIVE}, 8'h00);

    // watchdog recovery
    tick(1);
    for (k = 1; k <= 3; k++) begin
      tick(1);
      if (k == 2) check("rec_alive_early", {7'b0, SEL_ALIVE}, 8'h00);
      if (k == 3) check("rec_alive_rise", {7'b0, SEL_ALIVE}, 8'h01);
    end
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("rec_follow", JJOY, JSELECT ? 8'hBF : 8'hFE);
    end

    // reset mid-debounce
    P1_RAW = 8'hFF; P2_RAW = 8'hFF;
    for (int i = 0; i < 30; i++) tick(1);
    P1_RAW = 8'hFB;
    for (int i = 0; i < 10; i++) tick(1);
    RESET = 1'b1;
    tick(1);
    check("midrst_jjoy", JJOY, 8'hFF);
    check("midrst_alive", {7'b0, SEL_ALIVE}, 8'h00);
    RESET = 1'b0;
    for (k = 1; k <= LAT; k++) begin
      tick(1);
      if (k == LAT - 1) probe("midrst_before", 1'b0, 8'hFF);
      if (k == LAT) probe("midrst_accept", 1'b0, 8'hFB);
    end
    for (int i = 0; i < 10; i++) tick(1);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
